// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared types for the debounce bank. Holds the per-channel
//                hold/auto-repeat state type and its 2-bit encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Hold/auto-repeat state of one channel.
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,  // output low, or high but never risen since reset
        RPT_HOLD   = 2'd1,  // counting the initial hold delay
        RPT_REPEAT = 2'd2   // counting the auto-repeat period
    } rpt_state_t;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_ch
//  Description : One debounce channel: two-flop synchroniser, saturating
//                up/down integrator with hysteresis, registered edge pulses
//                and an optional hold-to-repeat pulse train.
//  Ports       : clk    - clock, all state on the rising edge
//                rst_n  - asynchronous active-low reset
//                i_in   - raw asynchronous input
//                o_out  - debounced level
//                o_rise - one-cycle pulse in the first cycle o_out reads 1
//                o_fall - one-cycle pulse in the first cycle o_out reads 0
//                o_rpt  - one-cycle hold/auto-repeat pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned WIDTH         = 20,
    parameter logic        INIT          = 1'b0,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned RPT_W         = 26,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned PERIOD_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_out,
    output logic o_rise,
    output logic o_fall,
    output logic o_rpt
);

    localparam logic [WIDTH-1:0] c_CNT_ONE = WIDTH'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_rise;
    logic             r_fall;

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= INIT;
            r_sync2 <= INIT;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
        end
    end

    // Integrator: the level only flips once the counter is pinned at a rail
    // and the sample still agrees, so short glitches merely move the count.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_out_nxt = r_out;
        if (r_sync2) begin
            if (&r_cnt) begin
                w_out_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
        end else begin
            if (r_cnt == '0) begin
                w_out_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
            end
        end
    end

    // Level and edge pulses share one register stage so they line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= {WIDTH{INIT}};
            r_out  <= INIT;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_out  <= w_out_nxt;
            r_rise <= w_out_nxt & ~r_out;
            r_fall <= ~w_out_nxt & r_out;
        end
    end

    assign o_out  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

    if (REPEAT_EN != 0) begin : g_rpt
        localparam logic [RPT_W-1:0] c_HOLD    = RPT_W'(HOLD_CYCLES);
        localparam logic [RPT_W-1:0] c_PERIOD  = RPT_W'(PERIOD_CYCLES);
        localparam logic [RPT_W-1:0] c_RPT_ONE = RPT_W'(1);

        rpt_state_t       r_state;
        rpt_state_t       w_state_nxt;
        logic [RPT_W-1:0] r_rcnt;
        logic [RPT_W-1:0] w_rcnt_nxt;
        logic             r_rpt;
        logic             w_rpt_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= RPT_IDLE;
                r_rcnt  <= '0;
                r_rpt   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_rcnt  <= w_rcnt_nxt;
                r_rpt   <= w_rpt_nxt;
            end
        end

        // The counter value k is held during the k-th cycle after the rise
        // cycle (or after the previous repeat). The pulse is registered from
        // the next-state view so it lands in the cycle where the count hits
        // its target.
        always_comb begin
            w_state_nxt = r_state;
            w_rcnt_nxt  = r_rcnt;
            case (r_state)
                RPT_IDLE: begin
                    w_rcnt_nxt = '0;
                    if (r_rise) begin
                        w_state_nxt = RPT_HOLD;
                        w_rcnt_nxt  = c_RPT_ONE;
                    end
                end
                RPT_HOLD: begin
                    if (r_rcnt == c_HOLD) begin
                        w_state_nxt = RPT_REPEAT;
                        w_rcnt_nxt  = c_RPT_ONE;
                    end else begin
                        w_rcnt_nxt = r_rcnt + c_RPT_ONE;
                    end
                end
                RPT_REPEAT: begin
                    if (r_rcnt == c_PERIOD) begin
                        w_rcnt_nxt = c_RPT_ONE;
                    end else begin
                        w_rcnt_nxt = r_rcnt + c_RPT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = RPT_IDLE;
                    w_rcnt_nxt  = '0;
                end
            endcase
            // Level dropping wins over everything: back to idle in the same
            // edge that produces the fall pulse, so no repeat in that cycle.
            if (!w_out_nxt) begin
                w_state_nxt = RPT_IDLE;
                w_rcnt_nxt  = '0;
            end
            w_rpt_nxt = w_out_nxt &&
                        (((w_state_nxt == RPT_HOLD)   && (w_rcnt_nxt == c_HOLD)) ||
                         ((w_state_nxt == RPT_REPEAT) && (w_rcnt_nxt == c_PERIOD)));
        end

        assign o_rpt = r_rpt;
    end else begin : g_no_rpt
        assign o_rpt = 1'b0;
    end

endmodule : debounce_ch
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bank
//  Description : CHANNELS independent debouncers for board buttons/switches,
//                each with edge pulses and optional hold-to-repeat.
//  Ports       : clk    - clock, all state on the rising edge
//                rst_n  - asynchronous active-low reset
//                i_in   - raw asynchronous inputs, one bit per channel
//                o_out  - debounced levels
//                o_rise - one-cycle pulses on 0->1 of o_out
//                o_fall - one-cycle pulses on 1->0 of o_out
//                o_rpt  - one-cycle hold/auto-repeat pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int unsigned CHANNELS      = 8,
    parameter int unsigned WIDTH         = 20,
    parameter logic        INIT          = 1'b0,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned RPT_W         = 26,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned PERIOD_CYCLES = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] i_in,
    output logic [CHANNELS-1:0] o_out,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic [CHANNELS-1:0] o_rpt
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_ch #(
            .WIDTH         (WIDTH),
            .INIT          (INIT),
            .REPEAT_EN     (REPEAT_EN),
            .RPT_W         (RPT_W),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .PERIOD_CYCLES (PERIOD_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_in   (i_in[g]),
            .o_out  (o_out[g]),
            .o_rise (o_rise[g]),
            .o_fall (o_fall[g]),
            .o_rpt  (o_rpt[g])
        );
    end

endmodule : debounce_bank
`default_nettype wire
